rcb_arb: RTL and testbench
==========================

# rcb_arb

Port arbiter and sequencer for one strategy RCB RAM (symbol, price, volume or order table). It shares the single RAM port between the tick-to-trade read path, which is never stalled, and host configuration accesses arriving from the HPB. Host accesses are confined to gaps between ticks, so every tick sees a consistent table snapshot. One instance sits between the HPB and each RCB RAM inside the strategy wrapper.

## Interface
Parameters:
- RAM_WIDTH, 64, RAM data width in bits.
- ADDR_WIDTH, 14, RAM address width in bits.
- MAX_WAIT, 1024, host wait-cycle threshold for the starvation flag (2..2^16-1).

Ports:
- clk  in  1  core clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- sef_busy  in  1  tick in flight; host access blocked while high.
- sef_read  in  1  strategy read strobe.
- t2t_rd_addr  in  ADDR_WIDTH  strategy read address.
- hst_req  in  1  host access request; held with its fields until hst_ack.
- hst_wr  in  1  1 = write, 0 = read.
- hst_addr  in  ADDR_WIDTH  host address.
- hst_wdata  in  RAM_WIDTH  host write data.
- hst_ack  out  1  one-cycle grant pulse.
- hst_rdata  out  RAM_WIDTH  registered host read data.
- hst_rvalid  out  1  one-cycle read-data-valid pulse.
- stat_clr  in  1  clears hst_starve.
- hst_starve  out  1  sticky starvation flag.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  RAM_WIDTH  RAM write data.
- ram_rdata  in  RAM_WIDTH  RAM read data; 1-cycle latency.
- rcb_data  out  RAM_WIDTH  strategy read data; combinational pass-through of ram_rdata.

## Operation
- Strategy path:
  - When sef_read=1: ram_en=1, ram_we=0, ram_addr=t2t_rd_addr, combinationally in the same cycle. No register in this path.
  - The strategy path has absolute priority in every state.
- Host grant condition: state IDLE, hst_req=1, sef_read=0, sef_busy=0.
- On grant:
  - hst_ack=1, ram_en=1, ram_we=hst_wr, ram_addr=hst_addr, ram_wdata=hst_wdata.
  - Write: stay in IDLE.
  - Read: go to RD_WAIT.
- FSM states:
  - IDLE: host grants allowed.
  - RD_WAIT: RAM output cycle. Capture ram_rdata into hst_rdata at the end of the cycle, then go to RD_DONE.
  - RD_DONE: hst_rvalid=1, then go to IDLE.
  - No host grant in RD_WAIT or RD_DONE. At most one host read is outstanding.
- Idle port drive: ram_we=0 and ram_en=0 whenever no access is issued. ram_addr and ram_wdata are don't-care then.
- Starvation counter:
  - 16-bit counter increments each cycle hst_req=1 without hst_ack.
  - Cleared on hst_ack or when hst_req=0.
  - Saturates at all-ones.
  - On reaching MAX_WAIT, set hst_starve.
  - hst_starve is cleared by stat_clr. If stat_clr and set occur in the same cycle, set wins.
- Boundary cases:
  - sef_busy falls while sef_read=1: host waits.
  - Host write and strategy read to the same address never coincide, because they are mutually exclusive by grant.
  - A host read captured during a later strategy read is unaffected: strategy reads do not alter hst_rdata.
  - hst_rdata holds its value until the next read capture.

## Timing
- Reset values: hst_ack=0, hst_rvalid=0, hst_rdata=0, hst_starve=0, counter=0, state=IDLE. ram_en, ram_we, ram_addr and ram_wdata are 0 while reset is asserted.
- Strategy read: address presented in cycle T, data on rcb_data in cycle T+1. Zero added latency.
- Host write: granted in cycle G; RAM written at the end of G.
- Host read: granted in G; hst_rvalid in G+2.
- Back-to-back host throughput:
  - Writes: one per cycle.
  - Reads: one per 3 cycles.
- Reset asserted mid-read: the read is abandoned and no hst_rvalid is produced. Reset takes effect asynchronously.

## Structure
- Shared package strategy_pkg:
  - arb_state_e enum (IDLE, RD_WAIT, RD_DONE).
  - Default width constants for the RCB tables (SRCB/PRCB/VRCB/ORCB address and data widths).
- No sub-module. The FSM, counter and muxes form one module of about 150–200 lines.

## Test plan
- Strategy read, idle host: sef_read=1, addr 0x0005, RAM holds 0xA5 → ram_en=1 and ram_addr=0x0005 in the same cycle; rcb_data=0xA5 the next cycle; hst_ack never asserted.
- Host write then read:
  - Write 0xDEADBEEF to 0x0100 → hst_ack in the first cycle.
  - Read 0x0100 → hst_ack at G, hst_rvalid at G+2 with hst_rdata=0xDEADBEEF.
- Hold-off: hst_req asserted while sef_busy=1 for 20 cycles → no hst_ack during those cycles; hst_ack on the first cycle with sef_busy=0 and sef_read=0.
- Collision: hst_req and sef_read in the same cycle → strategy address on ram_addr; hst_ack deferred to the next free cycle.
- Starvation: MAX_WAIT=8, sef_busy held high 10 cycles with hst_req=1 → hst_starve=1 after 8 waiting cycles and stays set after the grant. stat_clr → hst_starve=0 on the next cycle.
- Reset in RD_WAIT: reset_n pulsed low → no hst_rvalid, state IDLE; a new read then completes in 3 cycles.

Source files
------------

// File: rtl/strategy_pkg.sv
// Shared types and default RCB table geometry for the strategy wrapper.
package strategy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } arb_state_e;

  localparam int SRCB_AW = 14;
  localparam int SRCB_DW = 64;
  localparam int PRCB_AW = 12;
  localparam int PRCB_DW = 64;
  localparam int VRCB_AW = 12;
  localparam int VRCB_DW = 64;
  localparam int ORCB_AW = 14;
  localparam int ORCB_DW = 64;

  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/rcb_arb_if.sv
// Host (HPB) access channel into one RCB arbiter: request fields plus grant/read-return.
interface rcb_arb_if #(
  parameter int RAM_WIDTH  = 64,
  parameter int ADDR_WIDTH = 14
);
  logic                  hst_req;
  logic                  hst_wr;
  logic [ADDR_WIDTH-1:0] hst_addr;
  logic [RAM_WIDTH-1:0]  hst_wdata;
  logic                  hst_ack;
  logic [RAM_WIDTH-1:0]  hst_rdata;
  logic                  hst_rvalid;

  modport master (
    output hst_req, hst_wr, hst_addr, hst_wdata,
    input  hst_ack, hst_rdata, hst_rvalid
  );

  modport slave (
    input  hst_req, hst_wr, hst_addr, hst_wdata,
    output hst_ack, hst_rdata, hst_rvalid
  );
endinterface

// File: rtl/rcb_arb.sv
// Single-port RCB RAM arbiter: strategy reads pass straight through, host
// accesses slot into cycles between ticks, with a sticky starvation flag.
module rcb_arb
  import strategy_pkg::*;
#(
  parameter int RAM_WIDTH  = 64,
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_WAIT   = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sef_busy,
  input  logic                  sef_read,
  input  logic [ADDR_WIDTH-1:0] t2t_rd_addr,
  rcb_arb_if.slave              hst,
  input  logic                  stat_clr,
  output logic                  hst_starve,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]  ram_wdata,
  input  logic [RAM_WIDTH-1:0]  ram_rdata,
  output logic [RAM_WIDTH-1:0]  rcb_data
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  arb_state_e              state, state_nxt;
  logic                    grant;
  logic                    wait_inc;
  logic                    starve_set;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [RAM_WIDTH-1:0]    rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Port drive is gated by reset_n so the RAM sees a quiet port during reset.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state)
      IDLE: begin
        if (reset_n && hst.hst_req && !sef_read && !sef_busy) begin
          grant = 1'b1;
          if (!hst.hst_wr) state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset_n && sef_read) begin
      ram_en   = 1'b1;
      ram_addr = t2t_rd_addr;
    end else if (grant) begin
      ram_en    = 1'b1;
      ram_we    = hst.hst_wr;
      ram_addr  = hst.hst_addr;
      ram_wdata = hst.hst_wdata;
    end
  end

  assign hst.hst_ack    = grant;
  assign hst.hst_rvalid = (state == RD_DONE);
  assign hst.hst_rdata  = rdata_q;
  assign rcb_data       = ram_rdata;

  // RD_WAIT is the RAM output cycle of the granted host read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              rdata_q <= '0;
    else if (state == RD_WAIT) rdata_q <= ram_rdata;
  end

  assign wait_inc   = hst.hst_req && !grant;
  // WAIT_LAST never equals all-ones, so a saturated counter cannot re-fire.
  assign starve_set = wait_inc && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               wait_cnt <= '0;
    else if (!wait_inc)         wait_cnt <= '0;
    else if (wait_cnt != '1)    wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        hst_starve <= 1'b0;
    else if (starve_set) hst_starve <= 1'b1;
    else if (stat_clr)   hst_starve <= 1'b0;
  end

endmodule

// File: tb/tb_rcb_arb.sv
// Directed + randomized bench for rcb_arb with a behavioural RAM and scoreboard.
module tb_rcb_arb;
  localparam int RW = 64;
  localparam int AW = 14;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          sef_busy, sef_read, stat_clr;
  logic [AW-1:0] t2t_rd_addr;
  logic          hst_starve, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [RW-1:0] ram_wdata, ram_rdata, rcb_data;

  rcb_arb_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) hif ();

  rcb_arb #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .sef_busy(sef_busy), .sef_read(sef_read),
    .t2t_rd_addr(t2t_rd_addr), .hst(hif.slave), .stat_clr(stat_clr),
    .hst_starve(hst_starve), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rcb_data(rcb_data)
  );

  // Behavioural single-port RAM, one-cycle read latency.
  logic [RW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  logic [RW-1:0] ref_mem [0:(1<<AW)-1];
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [RW-1:0] d, output int waited);
    hif.hst_req = 1'b1; hif.hst_wr = 1'b1; hif.hst_addr = a; hif.hst_wdata = d;
    waited = 0;
    #3;
    while (!hif.hst_ack && waited < 60) begin step(); #3; waited++; end
    chk1("wr_ack", hif.hst_ack, 1'b1);
    chk1("wr_we", ram_we, 1'b1);
    chkw("wr_addr", RW'(ram_addr), RW'(a));
    chkw("wr_data", ram_wdata, d);
    ref_mem[a] = d;
    step();
    hif.hst_req = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output int waited);
    logic [RW-1:0] exp;
    hif.hst_req = 1'b1; hif.hst_wr = 1'b0; hif.hst_addr = a;
    waited = 0;
    #3;
    while (!hif.hst_ack && waited < 60) begin step(); #3; waited++; end
    chk1("rd_ack", hif.hst_ack, 1'b1);
    chk1("rd_we", ram_we, 1'b0);
    exp = ref_mem[a];
    step();
    hif.hst_req = 1'b0;
    #3;
    chk1("rd_rvalid_g1", hif.hst_rvalid, 1'b0);
    step(); #3;
    chk1("rd_rvalid_g2", hif.hst_rvalid, 1'b1);
    chkw("rd_data", hif.hst_rdata, exp);
    step();
  endtask

  // Random-phase scoreboard state
  logic          pend = 1'b0, pwr = 1'b0, exp_ack, st_m = 1'b0, prev_rd = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [RW-1:0] pdata = '0, prev_exp = '0, rd_exp = '0;
  int            rd_due = -1, free_at = 0, wcnt = 0, w;

  initial begin
    reset_n = 1'b0; sef_busy = 1'b0; sef_read = 1'b1; t2t_rd_addr = AW'(5); stat_clr = 1'b0;
    hif.hst_req = 1'b0; hif.hst_wr = 1'b0; hif.hst_addr = '0; hif.hst_wdata = '0;
    #3;
    chk1("rst_en", ram_en, 1'b0);
    chkw("rst_addr", RW'(ram_addr), '0);
    chk1("rst_ack", hif.hst_ack, 1'b0);
    chk1("rst_rvalid", hif.hst_rvalid, 1'b0);
    chkw("rst_rdata", hif.hst_rdata, '0);
    chk1("rst_starve", hst_starve, 1'b0);
    step();
    reset_n = 1'b1; sef_read = 1'b0;

    // Host write, back-to-back write, then read
    host_write(AW'('h100), RW'(64'hDEADBEEF), w);
    chk1("wr_first_cycle", w == 0, 1'b1);
    host_write(AW'(5), RW'(64'hA5), w);
    chk1("wr_b2b", w == 0, 1'b1);
    host_read(AW'('h100), w);
    chk1("rd_first_cycle", w == 0, 1'b1);

    // Strategy read with idle host
    sef_read = 1'b1; t2t_rd_addr = AW'(5);
    #3;
    chk1("st_en", ram_en, 1'b1);
    chk1("st_we", ram_we, 1'b0);
    chkw("st_addr", RW'(ram_addr), RW'(5));
    chk1("st_noack", hif.hst_ack, 1'b0);
    step(); sef_read = 1'b0; #3;
    chkw("st_data", rcb_data, RW'(64'hA5));
    step();

    // Hold-off under sef_busy with starvation
    sef_busy = 1'b1;
    hif.hst_req = 1'b1; hif.hst_wr = 1'b1; hif.hst_addr = AW'('h200); hif.hst_wdata = RW'(64'h1234);
    for (int k = 0; k < 20; k++) begin
      #3;
      chk1("hold_noack", hif.hst_ack, 1'b0);
      chk1("hold_starve", hst_starve, k >= MW);
      step();
    end
    sef_busy = 1'b0; #3;
    chk1("hold_ack", hif.hst_ack, 1'b1);
    ref_mem['h200] = RW'(64'h1234);
    step(); hif.hst_req = 1'b0; #3;
    chk1("starve_sticky", hst_starve, 1'b1);
    stat_clr = 1'b1;
    step(); stat_clr = 1'b0; #3;
    chk1("starve_clr", hst_starve, 1'b0);
    step();

    // Set beats a coincident stat_clr; a later clear works while still waiting
    sef_busy = 1'b1; hif.hst_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      stat_clr = 1'b0;
      #3;
      chk1("setwin_starve", hst_starve, (k >= MW) && (k < MW + 2));
      stat_clr = (k == MW - 1) || (k == MW + 1);
      step();
    end
    stat_clr = 1'b0;

    // sef_busy falls while sef_read is high: host still waits
    sef_busy = 1'b0; sef_read = 1'b1; t2t_rd_addr = AW'(5); #3;
    chk1("busyfall_noack", hif.hst_ack, 1'b0);
    chkw("busyfall_addr", RW'(ram_addr), RW'(5));
    step(); sef_read = 1'b0; #3;
    chk1("busyfall_ack", hif.hst_ack, 1'b1);
    step(); hif.hst_req = 1'b0;

    // Collision: host request and strategy read in the same cycle
    sef_read = 1'b1; t2t_rd_addr = AW'('h100);
    hif.hst_req = 1'b1; hif.hst_wr = 1'b1; hif.hst_addr = AW'('h300); hif.hst_wdata = RW'(64'h77);
    #3;
    chk1("coll_noack", hif.hst_ack, 1'b0);
    chkw("coll_addr", RW'(ram_addr), RW'('h100));
    chk1("coll_we", ram_we, 1'b0);
    step(); sef_read = 1'b0; #3;
    chk1("coll_ack", hif.hst_ack, 1'b1);
    chkw("coll_haddr", RW'(ram_addr), RW'('h300));
    chkw("coll_rcb", rcb_data, RW'(64'hDEADBEEF));
    ref_mem['h300] = RW'(64'h77);
    step(); hif.hst_req = 1'b0;

    // Back-to-back reads with request held, strategy read during second RD_WAIT
    hif.hst_req = 1'b1; hif.hst_wr = 1'b0; hif.hst_addr = AW'('h100); #3;
    chk1("b2b_ack_g", hif.hst_ack, 1'b1);
    step(); #3;
    chk1("b2b_noack_g1", hif.hst_ack, 1'b0);
    step(); #3;
    chk1("b2b_noack_g2", hif.hst_ack, 1'b0);
    chk1("b2b_rvalid", hif.hst_rvalid, 1'b1);
    chkw("b2b_rdata", hif.hst_rdata, RW'(64'hDEADBEEF));
    step(); #3;
    chk1("b2b_ack_g3", hif.hst_ack, 1'b1);
    step(); hif.hst_req = 1'b0; sef_read = 1'b1; t2t_rd_addr = AW'(5); #3;
    chkw("b2b_st_addr", RW'(ram_addr), RW'(5));
    step(); sef_read = 1'b0; #3;
    chk1("b2b_rvalid2", hif.hst_rvalid, 1'b1);
    chkw("b2b_rdata_under_st", hif.hst_rdata, RW'(64'hDEADBEEF));
    chkw("b2b_rcb", rcb_data, RW'(64'hA5));
    step();

    // Reset while in RD_WAIT abandons the read
    hif.hst_req = 1'b1; hif.hst_wr = 1'b0; hif.hst_addr = AW'(5); #3;
    chk1("rstrd_ack", hif.hst_ack, 1'b1);
    step(); hif.hst_req = 1'b0; reset_n = 1'b0; #3;
    chk1("rstrd_rvalid0", hif.hst_rvalid, 1'b0);
    chkw("rstrd_rdata", hif.hst_rdata, '0);
    step(); reset_n = 1'b1; #3;
    chk1("rstrd_rvalid1", hif.hst_rvalid, 1'b0);
    step(); #3;
    chk1("rstrd_rvalid2", hif.hst_rvalid, 1'b0);
    step();
    host_read(AW'('h100), w);
    chk1("rstrd_newread", w == 0, 1'b1);

    // Randomized phase over a small preloaded address window
    for (int a = 0; a < 16; a++) host_write(AW'(a), {$urandom, $urandom}, w);
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(1, 0) == 1) begin
        pend = 1'b1; pwr = 1'($urandom_range(1, 0));
        paddr = AW'($urandom_range(15, 0)); pdata = {$urandom, $urandom};
      end
      hif.hst_req = pend; hif.hst_wr = pwr; hif.hst_addr = paddr; hif.hst_wdata = pdata;
      sef_busy    = ($urandom_range(3, 0) == 0);
      sef_read    = 1'($urandom_range(1, 0));
      t2t_rd_addr = AW'($urandom_range(15, 0));
      stat_clr    = ($urandom_range(15, 0) == 0);
      #3;
      exp_ack = pend && !sef_read && !sef_busy && (c >= free_at);
      chk1("r_ack", hif.hst_ack, exp_ack);
      chk1("r_en", ram_en, sef_read || exp_ack);
      if (sef_read) chkw("r_addr", RW'(ram_addr), RW'(t2t_rd_addr));
      chk1("r_rvalid", hif.hst_rvalid, c == rd_due);
      if (c == rd_due) chkw("r_rdata", hif.hst_rdata, rd_exp);
      if (prev_rd) chkw("r_rcb", rcb_data, prev_exp);
      chk1("r_starve", hst_starve, st_m);
      prev_rd  = sef_read;
      prev_exp = ref_mem[t2t_rd_addr];
      if (pend && !exp_ack) begin
        wcnt++;
        if (wcnt == MW)    st_m = 1'b1;
        else if (stat_clr) st_m = 1'b0;
      end else begin
        wcnt = 0;
        if (stat_clr) st_m = 1'b0;
      end
      if (exp_ack) begin
        if (pwr) ref_mem[paddr] = pdata;
        else begin
          rd_due  = c + 2;
          rd_exp  = ref_mem[paddr];
          free_at = c + 3;
        end
        pend = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
